// File: rtl/lift53_inverse_if.sv
`default_nettype none
// ============================================================================
// Module   : lift53_inverse_if
// Desc     : Coefficient-in / sample-out stream bundle for the inverse 5/3
//            lifting block. The slave modport is the transform. The master
//            modport is the side that supplies pairs and consumes samples.
// Revision : 1.0  initial release
// ============================================================================
interface lift53_inverse_if #(
    parameter int W = 8
);
    // coefficient pair stream (source -> transform)
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_s;
    logic [W-1:0]   in_d;
    logic           in_last;

    // reconstructed sample stream (transform -> consumer)
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_x;
    logic           out_last;

    modport master (
        output in_valid, in_s, in_d, in_last, out_ready,
        input  in_ready, out_valid, out_x, out_last
    );

    modport slave (
        input  in_valid, in_s, in_d, in_last, out_ready,
        output in_ready, out_valid, out_x, out_last
    );
endinterface
`default_nettype wire

// File: rtl/lift53_inverse.sv
`default_nettype none
// ============================================================================
// Module   : lift53_inverse
// Desc     : Streaming inverse integer 5/3 lifting transform. Takes one
//            (s[n], d[n]) pair per transfer and emits x[0], x[1], ... one per
//            cycle through a 4-entry output FIFO. All state changes on the
//            falling edge of CLK. RST is synchronous and active-low.
// Revision : 1.0  initial release
// ============================================================================
module lift53_inverse #(
    parameter int W = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    lift53_inverse_if.slave       bus
);

    localparam int         c_DEPTH = 4;
    localparam logic [2:0] c_READY_MAX = 3'd1;   // a 3-sample push always fits

    // ------------------------------------------------------------------
    // Lifting state
    // ------------------------------------------------------------------
    logic           r_first;      // next accepted pair starts a frame
    logic [W-1:0]   r_d_prev;     // d[n-1]
    logic [W-1:0]   r_xe_prev;    // xe[n-1]
    logic           r_run;        // low from reset until the first released edge

    // ------------------------------------------------------------------
    // Output FIFO: entries are {last, sample}
    // ------------------------------------------------------------------
    logic [W:0]     r_mem [c_DEPTH];
    logic [1:0]     r_wr_ptr;
    logic [1:0]     r_rd_ptr;
    logic [2:0]     r_count;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic           w_in_ready;
    logic           w_accept;
    logic           w_out_valid;
    logic           w_pop;
    logic [W:0]     w_head;

    logic [W-1:0]   w_dp;          // left neighbour detail for the even step
    logic [W:0]     w_even_sum;    // dp + d[n] at W+1 bits
    logic [W-1:0]   w_even_q;      // floor((dp + d[n]) / 4), truncated
    logic [W-1:0]   w_xe;          // xe[n]
    logic [W:0]     w_odd_sum;     // xe[n-1] + xe[n] at W+1 bits
    logic [W-1:0]   w_odd_q;       // floor((xe[n-1] + xe[n]) / 2), truncated
    logic [W-1:0]   w_x_odd;       // x[2n-1]
    logic [W-1:0]   w_x_end;       // x[2N-1] under symmetric extension

    logic [1:0]     w_push_cnt;
    logic [W:0]     w_push [3];

    // Accept only when the FIFO can absorb a worst-case push; never looks at out_ready.
    assign w_in_ready  = r_run && (r_count <= c_READY_MAX);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_out_valid = (r_count != 3'd0);
    assign w_pop       = w_out_valid && bus.out_ready;
    assign w_head      = r_mem[r_rd_ptr];

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_x     = w_out_valid ? w_head[W-1:0] : '0;
    assign bus.out_last  = w_out_valid ? w_head[W]     : 1'b0;

    // Even (update-undo) and odd (predict-undo) lifting steps for the incoming pair.
    always_comb begin
        // At a frame start the missing left detail mirrors d[0].
        w_dp       = r_first ? bus.in_d : r_d_prev;
        w_even_sum = {w_dp[W-1], w_dp} + {bus.in_d[W-1], bus.in_d};
        w_even_q   = W'($signed(w_even_sum) >>> 2);
        w_xe       = bus.in_s - w_even_q;

        w_odd_sum  = {r_xe_prev[W-1], r_xe_prev} + {w_xe[W-1], w_xe};
        w_odd_q    = W'($signed(w_odd_sum) >>> 1);
        w_x_odd    = r_d_prev + w_odd_q;

        // Right edge: the mirrored xe[N] equals xe[N-1], so the average is xe[N-1].
        w_x_end    = bus.in_d + w_xe;
    end

    // Select which samples an accepted pair produces, in output order.
    always_comb begin
        w_push_cnt = 2'd0;
        w_push[0]  = '0;
        w_push[1]  = '0;
        w_push[2]  = '0;
        if (w_accept) begin
            case ({r_first, bus.in_last})
                2'b10: begin                         // frame start
                    w_push_cnt = 2'd1;
                    w_push[0]  = {1'b0, w_xe};
                end
                2'b11: begin                         // single-pair frame
                    w_push_cnt = 2'd2;
                    w_push[0]  = {1'b0, w_xe};
                    w_push[1]  = {1'b1, w_x_end};
                end
                2'b00: begin                         // middle of frame
                    w_push_cnt = 2'd2;
                    w_push[0]  = {1'b0, w_x_odd};
                    w_push[1]  = {1'b0, w_xe};
                end
                default: begin                       // last pair, N > 1
                    w_push_cnt = 2'd3;
                    w_push[0]  = {1'b0, w_x_odd};
                    w_push[1]  = {1'b0, w_xe};
                    w_push[2]  = {1'b1, w_x_end};
                end
            endcase
        end
    end

    // FIFO storage: write the pushed samples into consecutive free slots.
    always_ff @(negedge CLK) begin
        if (w_push_cnt > 2'd0) r_mem[r_wr_ptr]         <= w_push[0];
        if (w_push_cnt > 2'd1) r_mem[r_wr_ptr + 2'd1]  <= w_push[1];
        if (w_push_cnt > 2'd2) r_mem[r_wr_ptr + 2'd2]  <= w_push[2];
    end

    // FIFO pointers/occupancy and lifting history; reset drops any partial frame.
    always_ff @(negedge CLK) begin
        if (!RST) begin
            r_first   <= 1'b1;
            r_d_prev  <= '0;
            r_xe_prev <= '0;
            r_run     <= 1'b0;
            r_wr_ptr  <= 2'd0;
            r_rd_ptr  <= 2'd0;
            r_count   <= 3'd0;
        end else begin
            r_run <= 1'b1;
            if (w_accept) begin
                r_d_prev  <= bus.in_d;
                r_xe_prev <= w_xe;
                r_first   <= bus.in_last;
            end
            r_wr_ptr <= r_wr_ptr + w_push_cnt;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            r_count <= r_count + {1'b0, w_push_cnt} - {2'b00, w_pop};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lift53_inverse.sv
`default_nettype none
// ============================================================================
// Module   : tb_lift53_inverse
// Desc     : Directed self-checking bench for lift53_inverse. Expected
//            samples are hand-computed from the lifting equations.
// Revision : 1.0  initial release
// ============================================================================
module tb_lift53_inverse;

    localparam int W = 8;

    logic clk;
    logic rst_n;

    lift53_inverse_if #(.W(W)) bus ();

    lift53_inverse #(.W(W)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [W:0] got_q [$];
    logic [W:0] exp_q [$];

    // Record every output transfer ({last, x}) ahead of the falling edge that takes it.
    always @(posedge clk) begin
        #2;
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
            got_q.push_back({bus.out_last, bus.out_x});
    end

    // Inputs are driven and outputs observed 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one pair and hold it until it is accepted (bounded).
    task automatic send(input logic [W-1:0] s, input logic [W-1:0] d, input logic last);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_s     = s;
        bus.in_d     = d;
        bus.in_last  = last;
        while (bus.in_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("send_accept", 16'(bus.in_ready), 16'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_s     = 8'hA5;
        bus.in_d     = 8'h5A;
        bus.in_last  = 1'b1;
    endtask

    task automatic expect_sample(input logic [W-1:0] x, input logic last);
        exp_q.push_back({last, x});
    endtask

    // Wait for the expected number of transfers, then compare them in order.
    task automatic check_stream(input string tag);
        int n;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 40) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check({tag, "_count"}, 16'(got_q.size()), 16'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size())
                check($sformatf("%s[%0d]", tag, i), 16'(got_q[i]), 16'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_s      = '0;
        bus.in_d      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // ---- reset state ----
        repeat (3) tick();
        check("rst_out_valid", 16'(bus.out_valid), 16'd0);
        check("rst_out_x",     16'(bus.out_x),     16'd0);
        check("rst_out_last",  16'(bus.out_last),  16'd0);
        check("rst_in_ready",  16'(bus.in_ready),  16'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", 16'(bus.in_ready), 16'd1);
        got_q.delete();

        // ---- 1: two-pair frame, free-running consumer ----
        bus.out_ready = 1'b1;
        send(8'd10, 8'd0, 1'b0);
        send(8'd32, 8'd10, 1'b1);
        expect_sample(8'd10, 1'b0);
        expect_sample(8'd20, 1'b0);
        expect_sample(8'd30, 1'b0);
        expect_sample(8'd40, 1'b1);
        check_stream("frame2");

        // ---- 2: single pair, negative floor ----
        send(8'd5, 8'hFD, 1'b1);
        expect_sample(8'd7, 1'b0);
        expect_sample(8'd4, 1'b1);
        check_stream("single");

        // ---- 3: modular wrap ----
        send(8'd127, 8'h80, 1'b1);
        expect_sample(8'hBF, 1'b0);
        expect_sample(8'h3F, 1'b1);
        check_stream("wrap");

        // ---- three-pair frame: middle pair and interior left neighbour ----
        send(8'd10, 8'd0, 1'b0);
        send(8'd32, 8'd10, 1'b0);
        send(8'd20, 8'd4, 1'b1);
        expect_sample(8'd10, 1'b0);
        expect_sample(8'd20, 1'b0);
        expect_sample(8'd30, 1'b0);
        expect_sample(8'd33, 1'b0);
        expect_sample(8'd17, 1'b0);
        expect_sample(8'd21, 1'b1);
        check_stream("frame3");

        // ---- 4: backpressure ----
        bus.out_ready = 1'b0;
        send(8'd10, 8'd0, 1'b0);
        check("bp_lat_valid", 16'(bus.out_valid), 16'd1);
        check("bp_lat_x",     16'(bus.out_x),     16'd10);
        check("bp_in_ready1", 16'(bus.in_ready),  16'd1);
        send(8'd32, 8'd10, 1'b1);
        check("bp_full_in_ready", 16'(bus.in_ready), 16'd0);
        check("bp_full_x",        16'(bus.out_x),    16'd10);
        tick();
        check("bp_hold_x",    16'(bus.out_x),    16'd10);
        check("bp_hold_last", 16'(bus.out_last), 16'd0);
        check("bp_hold_in_ready", 16'(bus.in_ready), 16'd0);
        bus.out_ready = 1'b1;
        tick();
        check("bp_drain_x20",  16'(bus.out_x),    16'd20);
        check("bp_drain_rdy3", 16'(bus.in_ready), 16'd0);
        tick();
        check("bp_drain_x30",  16'(bus.out_x),    16'd30);
        check("bp_drain_rdy2", 16'(bus.in_ready), 16'd0);
        tick();
        check("bp_drain_x40",    16'(bus.out_x),    16'd40);
        check("bp_drain_last40", 16'(bus.out_last), 16'd1);
        check("bp_drain_rdy1",   16'(bus.in_ready), 16'd1);
        tick();
        check("bp_empty_valid", 16'(bus.out_valid), 16'd0);
        expect_sample(8'd10, 1'b0);
        expect_sample(8'd20, 1'b0);
        expect_sample(8'd30, 1'b0);
        expect_sample(8'd40, 1'b1);
        check_stream("bp");

        // ---- 5: back-to-back frames restart the left boundary ----
        send(8'd10, 8'd0, 1'b0);
        send(8'd32, 8'd10, 1'b1);
        send(8'd10, 8'd0, 1'b0);
        send(8'd32, 8'd10, 1'b1);
        for (int f = 0; f < 2; f++) begin
            expect_sample(8'd10, 1'b0);
            expect_sample(8'd20, 1'b0);
            expect_sample(8'd30, 1'b0);
            expect_sample(8'd40, 1'b1);
        end
        check_stream("b2b");

        // ---- 6: reset mid-frame ----
        bus.out_ready = 1'b0;
        send(8'd10, 8'd0, 1'b0);
        rst_n = 1'b0;
        tick();
        check("mrst_out_valid", 16'(bus.out_valid), 16'd0);
        check("mrst_out_x",     16'(bus.out_x),     16'd0);
        check("mrst_out_last",  16'(bus.out_last),  16'd0);
        check("mrst_in_ready",  16'(bus.in_ready),  16'd0);
        rst_n = 1'b1;
        tick();
        check("mrst_in_ready_back", 16'(bus.in_ready), 16'd1);
        got_q.delete();
        bus.out_ready = 1'b1;
        send(8'd5, 8'hFD, 1'b1);
        expect_sample(8'd7, 1'b0);
        expect_sample(8'd4, 1'b1);
        check_stream("mrst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lift53_inverse.md
Name: lift53_inverse

Overview:
- Streaming inverse integer 5/3 lifting wavelet transform. It is the reconstruction end of the team's forward predict/update lifting pipeline.
- Accepts interleaved coefficient pairs (approximation s[n], detail d[n]) one pair per transfer.
- Emits reconstructed samples x[0], x[1], x[2], … one per cycle over a valid/ready stream.
- Sits between the coefficient source (memory or channel) and the sample consumer.

Parameters:
- W, 8, width of coefficients and samples. All values are two's complement, arithmetic modulo 2^W.

Ports:
- CLK  input  1  clock. All state updates on the falling edge of CLK.
- RST  input  1  reset, synchronous, active-low.
- in_valid  input  1  coefficient pair present.
- in_ready  output  1  block can accept a pair this cycle.
- in_s  input  W  approximation coefficient s[n].
- in_d  input  W  detail coefficient d[n].
- in_last  input  1  pair is the final pair of the frame (N pairs → 2N samples).
- out_valid  output  1  out_x holds a sample.
- out_ready  input  1  consumer takes the sample this cycle.
- out_x  output  W  reconstructed sample.
- out_last  output  1  out_x is sample x[2N-1] of the frame.

Behaviour:
- Transfer rules: an input transfer occurs when in_valid && in_ready at the active edge. An output transfer occurs when out_valid && out_ready at the active edge.
- Lifting equations:
  - even step: xe[n] = s[n] - ((dp + d[n]) >>> 2)
  - odd step: x[2n-1] = d[n-1] + ((xe[n-1] + xe[n]) >>> 1)
  - Sums are formed at W+1 bits, arithmetic-shifted (floor), then truncated to W. Results wrap modulo 2^W.
- Boundary extension:
  - Frame start: dp = d[0]. Otherwise dp = d[n-1].
  - Frame end: symmetric extension, so x[2N-1] = d[N-1] + xe[N-1].
- Internal state: d_prev, xe_prev, first flag (1 = next pair starts a frame). The first flag sets after the last pair of a frame is accepted.
- Samples pushed into the 4-entry output FIFO per accepted pair, in order:
  - first pair, not last: xe[0]
  - middle pair: x[2n-1], then xe[n]
  - last pair, N>1: x[2N-3], xe[N-1], x[2N-1]
  - single-pair frame (first && last): xe[0], x[1]
- out_last is 1 only on x[2N-1].
- in_ready = (FIFO count <= 1). It depends only on registered count, never combinationally on out_ready. A worst-case push of 3 therefore always fits.
- Latency: a pair accepted at edge k presents its first sample with out_valid=1 after edge k. Pushed samples drain one per cycle while out_ready=1.
- A push and a pop in the same cycle are both honoured: count += pushes - 1.
- Output FIFO: out_x/out_last come from the FIFO head. They must stay stable while out_valid && !out_ready.
- Reset (RST=0 at an active edge), including mid-frame:
  - FIFO emptied, first=1, d_prev=0, xe_prev=0.
  - Outputs: out_valid=0, out_x=0, out_last=0, in_ready=0 during the reset cycle; in_ready=1 from the first edge after RST=1.
  - Partial frame data is discarded. The next pair is treated as a frame start.
- in_s/in_d/in_last are ignored when no transfer occurs.

Test Plan:
1. Frame pairs (s=10,d=0), (s=32,d=10,last), out_ready=1 → out_x 10, 20, 30, 40; out_last only on 40.
2. Single pair (s=5, d=-3, last) → out_x 7, then 4 with out_last=1. Checks floor on negative sums: (-6)>>>2 = -2.
3. Wrap, W=8, single pair (s=127, d=-128, last) → out_x 0xBF (-65), then 0x3F (63) with out_last=1.
4. Backpressure, out_ready=0:
   - Accept (10,0): count 1, in_ready stays 1.
   - Accept (32,10,last): count 4, in_ready=0.
   - Raise out_ready → 10, 20, 30, 40 drain on consecutive cycles; in_ready returns to 1 when count ≤ 1; out_x is held stable while stalled.
5. Two back-to-back frames, scenario 1 pairs repeated → second frame restarts boundary (dp=d[0]) and again yields 10, 20, 30, 40.
6. Reset mid-frame: after accepting (10,0), assert RST=0 for one edge, then send (5,-3,last) → out_valid=0 during reset; outputs only 7, 4 (10 is discarded, no stale sample).
